// File: rtl/rsa_modexp_core.sv
// rtl/rsa_modexp_core.sv - modular exponentiation a^d mod n via right-to-left square-and-multiply
//
// Ports:
//   i_clk      clock, all logic on the rising edge
//   i_rst_n    synchronous active-low reset
//   i_start    start request, only honoured while idle
//   i_a        base, expected < i_n
//   i_d        exponent
//   i_d_len    number of exponent LSBs to process (values above WIDTH clamp to WIDTH)
//   i_n        modulus, expected odd and > 1
//   o_a_pow_d  result, valid with o_finished and held until the next start
//   o_finished one-cycle completion pulse
//   o_busy     high from start acceptance through the o_finished cycle
module rsa_modexp_core #(
    parameter int WIDTH = 256,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_d,
    input  logic [LEN_W-1:0] i_d_len,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_a_pow_d,
    output logic             o_finished,
    output logic             o_busy
);

    // Accumulators carry two guard bits: Montgomery sums stay below 4n.
    localparam int AW    = WIDTH + 2;
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [LEN_W-1:0] LAST_CYC = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_LOOP, S_DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_reg, d_reg, n_reg, m_reg, t_reg;
    logic [LEN_W-1:0] d_len_reg, cyc, bit_cnt;
    logic [AW-1:0]    acc_m, acc_t;

    logic accept, prep_step, prep_last, loop_iter, pass_end, last_pass, done;

    function automatic logic [AW-1:0] cond_sub(input logic [AW-1:0] x, input logic [AW-1:0] n);
        return (x >= n) ? (x - n) : x;
    endfunction

    // One radix-2 Montgomery iteration: add b when the multiplier bit is set,
    // make the sum even by adding n, then halve.
    function automatic logic [AW-1:0] mont_step(input logic [AW-1:0] acc, input logic sel,
                                                 input logic [AW-1:0] b, input logic [AW-1:0] n);
        logic [AW-1:0] s;
        s = acc + (sel ? b : '0);
        if (s[0]) begin
            s = s + n;
        end
        return s >> 1;
    endfunction

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_PREP;
            S_PREP: if (prep_last) state_nxt = (d_len_reg != '0) ? S_LOOP : S_DONE;
            S_LOOP: if (last_pass) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control decode
    always_comb begin
        accept    = 1'b0;
        prep_step = 1'b0;
        prep_last = 1'b0;
        loop_iter = 1'b0;
        pass_end  = 1'b0;
        last_pass = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: accept = i_start;
            S_PREP: begin
                prep_step = 1'b1;
                prep_last = (cyc == LAST_CYC);
            end
            S_LOOP: begin
                loop_iter = (cyc != LAST_CYC);
                pass_end  = (cyc == LAST_CYC);
                last_pass = (cyc == LAST_CYC) && ((bit_cnt + ONE_L) == d_len_reg);
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Datapath values
    logic [AW-1:0] n_ext, t_ext, a_ext, dbl, prep_val;
    logic [AW-1:0] acc_m_in, acc_t_in, step_m, step_t, fin_m, fin_t;
    logic [IDX_W-1:0] bit_idx, exp_idx;

    always_comb begin
        n_ext   = {2'b00, n_reg};
        t_ext   = {2'b00, t_reg};
        a_ext   = {2'b00, a_reg};
        bit_idx = cyc[IDX_W-1:0];
        exp_idx = bit_cnt[IDX_W-1:0];
        // First prep cycle folds a into [0, n); the remaining WIDTH cycles
        // each double and reduce, giving a*2^WIDTH mod n.
        dbl      = {acc_t[AW-2:0], 1'b0};
        prep_val = (cyc == '0) ? cond_sub(a_ext, n_ext) : cond_sub(dbl, n_ext);
        acc_m_in = (cyc == '0) ? '0 : acc_m;
        acc_t_in = (cyc == '0) ? '0 : acc_t;
        // m stays in the normal domain: mont(m, a*R) = m*a.
        // t stays in the Montgomery domain: mont(t, t) = t^2 / R.
        step_m   = mont_step(acc_m_in, m_reg[bit_idx], t_ext, n_ext);
        step_t   = mont_step(acc_t_in, t_reg[bit_idx], t_ext, n_ext);
        fin_m    = cond_sub(acc_m, n_ext);
        fin_t    = cond_sub(acc_t, n_ext);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_reg      <= '0;
            d_reg      <= '0;
            n_reg      <= '0;
            m_reg      <= '0;
            t_reg      <= '0;
            d_len_reg  <= '0;
            cyc        <= '0;
            bit_cnt    <= '0;
            acc_m      <= '0;
            acc_t      <= '0;
            o_a_pow_d  <= '0;
            o_finished <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_finished <= done;

            // A start accepted in the o_finished cycle keeps busy asserted.
            if (accept) begin
                o_busy <= 1'b1;
            end else if (o_finished) begin
                o_busy <= 1'b0;
            end

            if (accept) begin
                a_reg     <= i_a;
                d_reg     <= i_d;
                n_reg     <= i_n;
                d_len_reg <= (i_d_len > LAST_CYC) ? LAST_CYC : i_d_len;
                m_reg     <= WIDTH'(1);
                t_reg     <= '0;
                acc_m     <= '0;
                acc_t     <= '0;
                cyc       <= '0;
                bit_cnt   <= '0;
            end

            if (prep_step) begin
                acc_t <= prep_val;
                cyc   <= prep_last ? '0 : cyc + ONE_L;
                if (prep_last) begin
                    t_reg <= prep_val[WIDTH-1:0];
                end
            end

            if (loop_iter) begin
                acc_m <= step_m;
                acc_t <= step_t;
                cyc   <= cyc + ONE_L;
            end

            if (pass_end) begin
                if (d_reg[exp_idx]) begin
                    m_reg <= fin_m[WIDTH-1:0];
                end
                t_reg   <= fin_t[WIDTH-1:0];
                cyc     <= '0;
                bit_cnt <= bit_cnt + ONE_L;
            end

            if (done) begin
                o_a_pow_d <= m_reg;
            end
        end
    end

endmodule
